// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor that walks a WIDTH-bit operation
// through a CHUNK-bit ripple stage, one chunk per clock, with the inter-chunk
// carry held in a register.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, c_in, sub     operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   sum                 WIDTH-bit result (modulo 2^WIDTH)
//   c_out               carry out of the MSB (for subtract: 1 = no borrow)
//   overflow            signed overflow
//   zero                sum == 0
//   dbg_state           current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds its data stable while valid is high; this block
// samples operands only on the accepting edge and holds all result outputs
// constant while out_valid is high and out_ready is low.
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Operand registers shift right by CHUNK every BUSY cycle, so the chunk
  // being worked on is always in the low bits; finished result chunks enter
  // the sum register from the top and reach their final position after N
  // cycles.
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_full;
  logic             c_msb;
  logic [WIDTH-1:0] sum_shift;

  always_comb begin
    a_chunk    = a_q[CHUNK-1:0];
    b_chunk    = b_q[CHUNK-1:0];
    chunk_full = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit of this chunk, recovered from the sum bit.
    c_msb      = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_full[CHUNK-1];
    sum_shift  = (sum_q >> CHUNK) | (WIDTH'(chunk_full[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtract is a + ~b + !c_in: invert b and the carry-in up front.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = c_in ^ sub;
          k_d     = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = sum_shift;
        carry_d = chunk_full[CHUNK];
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          c_out_d = chunk_full[CHUNK];
          ovf_d   = chunk_full[CHUNK] ^ c_msb;
          zero_d  = (sum_shift == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: four instances (32/8, 32/1, 32/32, 16/4) share clock
// and reset; directed vectors, backpressure and mid-operation reset run on the
// 32/8 instance, then randomized operations on every instance are checked
// against an arithmetic reference model.
module tb_seq_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a_s [4];
  logic [31:0] b_s [4];
  logic [3:0]  in_valid_v, c_in_v, sub_v, out_ready_v;
  logic [3:0]  in_ready_v, out_valid_v, c_out_v, ovf_v, zero_v;
  logic [31:0] sum_w0, sum_w1, sum_w2;
  logic [15:0] sum_w3;
  logic [7:0]  dbg_all;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a, b;
    logic        ci, sb;
    logic [31:0] es;
    logic        ec, eo, ez;
  } vec_t;

  seq_addsub #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_s[0]), .b(b_s[0]), .c_in(c_in_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .sum(sum_w0),
    .c_out(c_out_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]), .dbg_state(dbg_all[1:0]));

  seq_addsub #(.WIDTH(32), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_s[1]), .b(b_s[1]), .c_in(c_in_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .sum(sum_w1),
    .c_out(c_out_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]), .dbg_state(dbg_all[3:2]));

  seq_addsub #(.WIDTH(32), .CHUNK(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_s[2]), .b(b_s[2]), .c_in(c_in_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .sum(sum_w2),
    .c_out(c_out_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]), .dbg_state(dbg_all[5:4]));

  seq_addsub #(.WIDTH(16), .CHUNK(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .a(a_s[3][15:0]), .b(b_s[3][15:0]), .c_in(c_in_v[3]), .sub(sub_v[3]),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]), .sum(sum_w3),
    .c_out(c_out_v[3]), .overflow(ovf_v[3]), .zero(zero_v[3]), .dbg_state(dbg_all[7:6]));

  function automatic int w_of(input int u);
    return (u == 3) ? 16 : 32;
  endfunction

  function automatic int n_of(input int u);
    case (u)
      0:       return 4;
      1:       return 32;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] sum_of(input int u);
    case (u)
      0:       return sum_w0;
      1:       return sum_w1;
      2:       return sum_w2;
      default: return {16'h0, sum_w3};
    endcase
  endfunction

  // Reference: exact integer arithmetic, signed overflow from the true range.
  task automatic ref_model(input int w, input logic [31:0] a, b, input logic ci, is_sub,
                           output logic [31:0] s, output logic co, ov, zr);
    longint unsigned mask, ua, ub, full, half;
    longint sa, sbv, res;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    ua = {32'h0, a} & mask;
    ub = {32'h0, b} & mask;
    if (!is_sub) full = ua + ub + {63'd0, ci};
    else         full = ua + (~ub & mask) + {63'd0, !ci};
    s  = 32'(full & mask);
    co = full[w];
    sa  = (ua >= half) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sbv = (ub >= half) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    res = is_sub ? sa - sbv - longint'(ci) : sa + sbv + longint'(ci);
    ov  = (res < -longint'(half)) || (res > longint'(half) - 1);
    zr  = (s == 32'h0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic scramble(input int u);
    a_s[u] = $urandom;
    b_s[u] = $urandom;
    c_in_v[u] = 1'($urandom);
    sub_v[u]  = 1'($urandom);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge where
  // out_valid was first seen, with lat = rising edges after the accept edge.
  task automatic start_op(input int u, input logic [31:0] a, b, input logic ci, sb,
                          output int lat);
    logic busy_rdy;
    busy_rdy = 1'b0;
    chk($sformatf("u%0d_idle_in_ready", u), 64'(in_ready_v[u]), 64'd1);
    a_s[u] = a; b_s[u] = b; c_in_v[u] = ci; sub_v[u] = sb; in_valid_v[u] = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!out_valid_v[u] && lat < 64) begin
      busy_rdy |= in_ready_v[u];
      scramble(u);
      in_valid_v[u] = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("u%0d_busy_in_ready", u), 64'(busy_rdy), 64'd0);
    chk($sformatf("u%0d_latency", u), 64'(lat), 64'(n_of(u)));
    chk($sformatf("u%0d_done_in_ready", u), 64'(in_ready_v[u]), 64'd0);
  endtask

  // Holds the result for 'hold' cycles with noisy inputs, then acknowledges
  // it with in_valid high on the same edge; nothing must be accepted.
  task automatic ack_op(input int u, input int hold);
    logic [31:0] s0;
    logic [3:0]  f0;
    logic [7:0]  d0;
    logic        moved;
    s0 = sum_of(u);
    f0 = {out_valid_v[u], c_out_v[u], ovf_v[u], zero_v[u]};
    d0 = dbg_all;
    moved = 1'b0;
    for (int i = 0; i < hold; i++) begin
      out_ready_v[u] = 1'b0;
      scramble(u);
      in_valid_v[u] = 1'($urandom);
      @(negedge clk);
      if (sum_of(u) !== s0 || {out_valid_v[u], c_out_v[u], ovf_v[u], zero_v[u]} !== f0 ||
          in_ready_v[u] !== 1'b0 || dbg_all !== d0)
        moved = 1'b1;
    end
    if (hold > 0) chk($sformatf("u%0d_hold_stable", u), 64'(moved), 64'd0);
    out_ready_v[u] = 1'b1;
    in_valid_v[u]  = 1'b1;
    @(negedge clk);
    out_ready_v[u] = 1'b0;
    in_valid_v[u]  = 1'b0;
    chk($sformatf("u%0d_ack_idle", u), 64'({out_valid_v[u], in_ready_v[u]}), 64'b01);
  endtask

  task automatic run_vec(input int u, input logic [31:0] a, b, input logic ci, sb,
                         input logic [31:0] es, input logic ec, eo, ez, input int hold);
    int lat;
    start_op(u, a, b, ci, sb, lat);
    chk($sformatf("u%0d_sum a=%0h b=%0h", u, a, b), 64'(sum_of(u)), 64'(es));
    chk($sformatf("u%0d_c_out", u), 64'(c_out_v[u]), 64'(ec));
    chk($sformatf("u%0d_overflow", u), 64'(ovf_v[u]), 64'(eo));
    chk($sformatf("u%0d_zero", u), 64'(zero_v[u]), 64'(ez));
    ack_op(u, hold);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    logic [31:0] ra, rb, es;
    logic        rci, rsb, ec, eo, ez;
    logic        stale;
    int          iters;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'd1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'd10,        32'd3,         1'b1, 1'b1, 32'd6,         1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'd0,         32'd0,         1'b0, 1'b1, 32'd0,         1'b1, 1'b0, 1'b1};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0,         1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'd0,         32'd0,         1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    // Clock/reset
    rst_n = 1'b0;
    in_valid_v = '0; c_in_v = '0; sub_v = '0; out_ready_v = '0;
    for (int u = 0; u < 4; u++) begin a_s[u] = '0; b_s[u] = '0; end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("u%0d_reset_flags", u),
          64'({in_ready_v[u], out_valid_v[u], c_out_v[u], ovf_v[u], zero_v[u]}), 64'b10000);
      chk($sformatf("u%0d_reset_sum", u), 64'(sum_of(u)), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 9; i++)
      run_vec(0, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb,
              tbl[i].es, tbl[i].ec, tbl[i].eo, tbl[i].ez, 0);

    // Backpressure: ten cycles of stall with noisy inputs
    run_vec(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 10);

    // Reset two BUSY cycles into an operation
    a_s[0] = 32'h1122_3344; b_s[0] = 32'h0101_0101; c_in_v[0] = 1'b0; sub_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("u0_async_reset_flags",
        64'({in_ready_v[0], out_valid_v[0], c_out_v[0], ovf_v[0], zero_v[0]}), 64'b10000);
    chk("u0_async_reset_sum", 64'(sum_of(0)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      stale |= out_valid_v[0] | ~in_ready_v[0];
    end
    chk("u0_no_stale_result", 64'(stale), 64'd0);
    run_vec(0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 0);

    // Randomized sweep over all four parameter sets
    for (int u = 0; u < 4; u++) begin
      iters = (u == 0) ? 300 : 1000;
      for (int i = 0; i < iters; i++) begin
        ra  = $urandom;
        rb  = $urandom;
        rci = 1'($urandom);
        rsb = 1'($urandom);
        case ($urandom_range(0, 9))
          0: ra = 32'h0;
          1: ra = 32'hFFFF_FFFF;
          2: ra = 32'd1 << (w_of(u) - 1);
          3: rb = 32'hFFFF_FFFF;
          4: rb = ra;
          default: ;
        endcase
        if (w_of(u) == 16) begin ra[31:16] = '0; rb[31:16] = '0; end
        ref_model(w_of(u), ra, rb, rci, rsb, es, ec, eo, ez);
        run_vec(u, ra, rb, rci, rsb, es, ec, eo, ez, $urandom_range(0, 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
# seq_addsub

Parametrised multi-cycle adder/subtractor for the sequential processor datapath. Processes a WIDTH-bit operation CHUNK bits per clock through a chunk-wide ripple stage, carrying between chunks in a register. Trades latency for area. Uses a valid/ready handshake on input and output so the control FSM can stall on it. Produces the sum plus carry, signed-overflow and zero flags.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK is the number of compute cycles.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low. One clock; reset is asynchronous and active-low.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a, b  in  WIDTH  operands.
- c_in  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of bit WIDTH-1; for sub, 1 = no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Effective carry-in: cin_eff = c_in XOR sub. Effective B operand: b XOR {WIDTH{sub}}.
  - add: a + b + c_in.
  - sub: a − b − c_in, computed as a + ~b + !c_in.
- States:
  - IDLE: in_ready = 1. On in_valid·in_ready, latch a, b_eff, cin_eff into internal registers, clear chunk counter k = 0, go to BUSY.
  - BUSY: each cycle, add chunk k (bits k·CHUNK .. k·CHUNK+CHUNK−1) of a and b_eff with the carry register. Write result bits into the sum register, update the carry register, increment k.
    - On the cycle with k = N−1, also capture the carry into the MSB as c_msb, then go to DONE.
  - DONE: out_valid = 1. sum, c_out, overflow and zero are held stable. On out_valid·out_ready, go to IDLE.
- Flags:
  - c_out = final carry.
  - overflow = c_out XOR c_msb.
  - zero = (sum == 0).
  - Flags are registered and valid whenever out_valid = 1.
- Input signals are ignored outside IDLE. Operand changes during BUSY or DONE have no effect.
- out_ready outside DONE is ignored.
- No accept in DONE, even when out_ready is high in the same cycle: one operation in flight.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, k = 0. Outputs:
  - in_ready = 1.
  - out_valid = 0.
  - sum = 0, c_out = 0, overflow = 0, zero = 0.
- Reset during BUSY or DONE aborts the operation. The result is discarded and never presented.
- Latency:
  - Accept on edge E0.
  - BUSY occupies edges E1..EN.
  - out_valid is high after EN, i.e. N cycles after the accept edge.
- Result handshake: earliest on edge EN+1. in_ready is high after that edge. Next accept is earliest on EN+2.
- Peak throughput: one operation per N+2 cycles.
- Backpressure: DONE is held indefinitely while out_ready = 0. All outputs stay constant.
- CHUNK = WIDTH (N = 1): a single BUSY cycle. out_valid is high 1 cycle after accept.
- sum, c_out, overflow and zero may change during BUSY. They are only meaningful when out_valid = 1.

## Test plan
- Add wrap, WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, c_in=0, sub=0 → sum=0x00000000, c_out=1, overflow=0, zero=1. out_valid rises exactly 4 cycles after the accept edge; in_ready=0 over that interval.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, add → sum=0x80000000, c_out=0, overflow=1, zero=0. Carry chain: a=0x00FF00FF, b=0x00010001, c_in=1 → sum=0x01000101, c_out=0.
- Subtract:
  - 5 − 7, c_in=0 → sum=0xFFFFFFFE, c_out=0, overflow=0.
  - 0x80000000 − 1 → sum=0x7FFFFFFF, c_out=1, overflow=1.
  - 10 − 3 with c_in=1 → sum=6.
- Backpressure: after result, hold out_ready=0 for 10 cycles and toggle a, b and in_valid → out_valid stays 1, outputs unchanged, in_ready=0, nothing accepted. Raise out_ready → in_ready=1 next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously after 2 BUSY cycles → outputs immediately go to 0, in_ready=1. Release reset and issue 3+4 → sum=7 with normal latency, and no stale result appears.
- Parameter sweep: CHUNK=1 (N=32), CHUNK=32 (N=1) and WIDTH=16/CHUNK=4. Run 1000 random add/sub operations each against a reference model. Check latency equals N and all four outputs match.
